bgr_startup_seq: RTL
====================

Name: bgr_startup_seq

Overview:
- Digital start-up sequencer directly upstream of the bandgap core.
- Drives the bandgap start-up pull-down gate (porst).
- Watches an analog "vbg in range" comparator flag, waits for settling, and retries the kick on failure.
- Issues bgr_ready to downstream consumers (LDOs, ADC references) once vbg is good; reports a sticky fault after the retry budget is exhausted.

Parameters:
PULSE_CYCLES, 16, number of cycles porst is held high per kick (>=1)
SETTLE_CYCLES, 256, cycles after porst falls before vbg_ok is evaluated (>=1)
MAX_RETRIES, 3, extra kicks allowed after the first one fails (0..2^RETRY_W-1)
CNT_W, 10, width of the shared phase counter; must hold max(PULSE_CYCLES, SETTLE_CYCLES)
RETRY_W, 2, width of retry_cnt

Ports:
clk  input  1  sequencer clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  synchronous request to power up the bandgap; low = shut down and clear
vbg_ok  input  1  asynchronous comparator output, high when vbg is within window
porst  output  1  bandgap start-up kick, active high (drives the start-up NMOS gate)
bgr_ready  output  1  vbg valid and stable
fault  output  1  sticky: all kicks failed
retry_cnt  output  RETRY_W  retries consumed in the current enable session
state_o  output  3  current FSM state encoding, for debug

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n (clock port clk).
- Reset values:
  - porst=0, bgr_ready=0, fault=0, retry_cnt=0, state=IDLE.
  - Counter=0; synchronizer flops=0.
- All outputs are registered.
- vbg_ok passes through a 2-flop synchronizer to give vbg_ok_s, which adds 2 cycles of latency. Only vbg_ok_s is used by the FSM.
- State encodings: IDLE=0, KICK=1, SETTLE=2, READY=3, FAULT=4.
- IDLE: all outputs 0. When enable=1 at an edge: go to KICK, counter=0, porst=1 from that edge.
- KICK:
  - porst=1 for exactly PULSE_CYCLES cycles.
  - When counter==PULSE_CYCLES-1: go to SETTLE, porst=0, counter=0.
- SETTLE:
  - porst=0. Counts SETTLE_CYCLES cycles.
  - At counter==SETTLE_CYCLES-1, evaluate vbg_ok_s:
    - 1: go to READY, bgr_ready=1 at that edge.
    - 0 and retry_cnt<MAX_RETRIES: retry_cnt+1, go to KICK (porst=1 at that edge).
    - 0 and retry_cnt==MAX_RETRIES: go to FAULT, fault=1.
- READY:
  - bgr_ready=1.
  - Dropout: vbg_ok_s=0 sampled → bgr_ready=0 at the same edge, retry_cnt cleared to 0, go to KICK.
- FAULT:
  - fault=1, bgr_ready=0, porst=0. No further kicks.
  - Leaves only when enable=0.
- enable=0 in any state: at that edge go to IDLE, all outputs and counters cleared, fault cleared. This has priority over every other transition, including the SETTLE evaluation edge.
- Nominal latency from the enable edge to bgr_ready rising: PULSE_CYCLES+SETTLE_CYCLES cycles.
- retry_cnt saturates at MAX_RETRIES and never wraps.
- rst_n asserted mid-kick: porst drops immediately (asynchronously).
- vbg_ok toggling during KICK or early SETTLE has no effect; only the final SETTLE cycle is sampled.

Optional Feature:
BGR_SEQ_DEGLITCH_EN
- Defined: in READY, dropout is declared only after vbg_ok_s has been 0 for 4 consecutive cycles (2-bit run counter, cleared whenever vbg_ok_s=1). bgr_ready falls at the edge that sees the 4th low sample.
- Undefined: a single low sample of vbg_ok_s in READY triggers dropout.
- All other behaviour is identical either way.

Test Plan (PULSE_CYCLES=4, SETTLE_CYCLES=8, MAX_RETRIES=2):
- Reset, then enable=1 with vbg_ok held 1 → porst high for exactly 4 cycles; bgr_ready rises 12 cycles after porst rises; retry_cnt=0; fault=0.
- vbg_ok held 0, then enable=1 → 3 porst pulses of 4 cycles each, spaced 12 cycles apart; retry_cnt steps 0→1→2; fault=1 at cycle 36; porst stays 0 afterwards.
- vbg_ok=0 for the first attempt, rising to 1 during the second SETTLE → bgr_ready rises at cycle 24; retry_cnt=1.
- In READY, pulse vbg_ok low for 1 cycle:
  - without BGR_SEQ_DEGLITCH_EN → bgr_ready falls 3 cycles later, a new 4-cycle porst pulse starts, retry_cnt=0.
  - with BGR_SEQ_DEGLITCH_EN → bgr_ready stays 1; a 4-cycle low triggers the re-kick.
- From FAULT, drop enable for 1 cycle, then raise it with vbg_ok=1 → fault clears, a fresh sequence runs, bgr_ready rises 12 cycles after porst rises.
- Assert rst_n=0 in the 2nd cycle of KICK → porst=0 immediately with no clock edge; all outputs 0; after release with enable=1, sequencing restarts from KICK.

Source files
------------

// File: rtl/bgr_startup_seq_if.sv
// Control/status bundle between the bandgap start-up sequencer and its
// environment: enable and comparator flag in, kick/ready/fault/debug out.
interface bgr_startup_seq_if #(
  parameter int RETRY_W = 2
);
  logic               enable;
  logic               vbg_ok;
  logic               porst;
  logic               bgr_ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         state_o;

  modport master (
    output enable,
    output vbg_ok,
    input  porst,
    input  bgr_ready,
    input  fault,
    input  retry_cnt,
    input  state_o
  );

  modport slave (
    input  enable,
    input  vbg_ok,
    output porst,
    output bgr_ready,
    output fault,
    output retry_cnt,
    output state_o
  );
endinterface

// File: rtl/bgr_startup_seq.sv
// Bandgap start-up sequencer: kick, settle, check vbg_ok, retry or fault.
// Optional READY dropout deglitch (4 consecutive low samples): BGR_SEQ_DEGLITCH_EN.
module bgr_startup_seq #(
  parameter int PULSE_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 10,
  parameter int RETRY_W       = 2
) (
  input logic              clk,
  input logic              rst_n,
  bgr_startup_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KICK   = 3'd1,
    SETTLE = 3'd2,
    READY  = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               porst_r, porst_s;
  logic               ready_r, ready_s;
  logic               fault_r, fault_s;
  logic [RETRY_W-1:0] retry_r, retry_s;
  logic               sync1_r, sync2_r;
  logic               vbg_ok_s;
`ifdef BGR_SEQ_DEGLITCH_EN
  logic [1:0]         glitch_r, glitch_s;
`endif

  assign vbg_ok_s = sync2_r;

  // Two-flop synchronizer for the asynchronous comparator flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= bus.vbg_ok;
      sync2_r <= sync1_r;
    end
  end

  // State, phase counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      porst_r  <= 1'b0;
      ready_r  <= 1'b0;
      fault_r  <= 1'b0;
      retry_r  <= {RETRY_W{1'b0}};
`ifdef BGR_SEQ_DEGLITCH_EN
      glitch_r <= 2'd0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      porst_r  <= porst_s;
      ready_r  <= ready_s;
      fault_r  <= fault_s;
      retry_r  <= retry_s;
`ifdef BGR_SEQ_DEGLITCH_EN
      glitch_r <= glitch_s;
`endif
    end
  end

  // Next-state and next-output decode; enable low overrides every transition.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    porst_s  = porst_r;
    ready_s  = ready_r;
    fault_s  = fault_r;
    retry_s  = retry_r;
`ifdef BGR_SEQ_DEGLITCH_EN
    glitch_s = glitch_r;
`endif
    if (!bus.enable) begin
      state_s  = IDLE;
      cnt_s    = {CNT_W{1'b0}};
      porst_s  = 1'b0;
      ready_s  = 1'b0;
      fault_s  = 1'b0;
      retry_s  = {RETRY_W{1'b0}};
`ifdef BGR_SEQ_DEGLITCH_EN
      glitch_s = 2'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_s = KICK;
          cnt_s   = {CNT_W{1'b0}};
          porst_s = 1'b1;
          ready_s = 1'b0;
          fault_s = 1'b0;
        end
        KICK: begin
          if (cnt_r == PULSE_LAST) begin
            state_s = SETTLE;
            cnt_s   = {CNT_W{1'b0}};
            porst_s = 1'b0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        SETTLE: begin
          // Comparator is only trusted on the last settle cycle.
          if (cnt_r == SETTLE_LAST) begin
            cnt_s = {CNT_W{1'b0}};
            if (vbg_ok_s) begin
              state_s  = READY;
              ready_s  = 1'b1;
`ifdef BGR_SEQ_DEGLITCH_EN
              glitch_s = 2'd0;
`endif
            end else if (retry_r < RETRY_MAX) begin
              state_s = KICK;
              porst_s = 1'b1;
              retry_s = retry_r + RETRY_W'(1);
            end else begin
              state_s = FAULT;
              fault_s = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        READY: begin
`ifdef BGR_SEQ_DEGLITCH_EN
          if (vbg_ok_s) begin
            glitch_s = 2'd0;
          end else if (glitch_r == 2'd3) begin
            state_s  = KICK;
            cnt_s    = {CNT_W{1'b0}};
            porst_s  = 1'b1;
            ready_s  = 1'b0;
            retry_s  = {RETRY_W{1'b0}};
            glitch_s = 2'd0;
          end else begin
            glitch_s = glitch_r + 2'd1;
          end
`else
          if (!vbg_ok_s) begin
            state_s = KICK;
            cnt_s   = {CNT_W{1'b0}};
            porst_s = 1'b1;
            ready_s = 1'b0;
            retry_s = {RETRY_W{1'b0}};
          end else begin
            state_s = READY;
          end
`endif
        end
        FAULT: begin
          state_s = FAULT;
          porst_s = 1'b0;
          ready_s = 1'b0;
          fault_s = 1'b1;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
          porst_s = 1'b0;
          ready_s = 1'b0;
          fault_s = 1'b0;
          retry_s = {RETRY_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.porst     = porst_r;
  assign bus.bgr_ready = ready_r;
  assign bus.fault     = fault_r;
  assign bus.retry_cnt = retry_r;
  assign bus.state_o   = state_r;

endmodule
